// File: rtl/wino_f23_mc_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wino_f23_mc_engine_pkg : shared widths, tile types, saturation helper |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package wino_f23_mc_engine_pkg;

  localparam int DW_DEF = 10;
  localparam int GW_DEF = 10;
  localparam int OW_DEF = 10;

  typedef logic signed [DW_DEF-1:0] sample_t;
  typedef logic signed [GW_DEF-1:0] tap_t;
  typedef struct packed { sample_t d3, d2, d1, d0; } tile_t;
  typedef struct packed { tap_t g2, g1, g0; } taps_t;

  function automatic int chw_calc(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic int aw_calc(input int dw, input int gw, input int ch);
    return dw + gw + 4 + $clog2(ch + 1);
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_ovf(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wino_f23_mc_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wino_f23_mc_engine_if : tile, output and filter-write handshakes      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface wino_f23_mc_engine_if
  import wino_f23_mc_engine_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int GW = GW_DEF,
  parameter int OW = OW_DEF,
  parameter int CH = 1
) ();

  localparam int CHW = chw_calc(CH);

  logic              in_valid;
  logic              in_ready;
  logic [4*DW-1:0]   in_d;
  logic              out_valid;
  logic              out_ready;
  logic [2*OW-1:0]   out_z;
  logic              out_ovf;
  logic              w_we;
  logic              w_ready;
  logic [CHW-1:0]    w_ch;
  logic [3*GW-1:0]   w_g;

  modport master (
    output in_valid, in_d, out_ready, w_we, w_ch, w_g,
    input  in_ready, out_valid, out_z, out_ovf, w_ready
  );

  modport slave (
    input  in_valid, in_d, out_ready, w_we, w_ch, w_g,
    output in_ready, out_valid, out_z, out_ovf, w_ready
  );

endinterface

`default_nettype wire

// File: rtl/wino_f23_mc_engine_wbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wino_f23_wbank : per-channel store of transformed filter taps u0..u3  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module wino_f23_wbank
  import wino_f23_mc_engine_pkg::*;
#(
  parameter int CH  = 1,
  parameter int UW  = GW_DEF + 2,
  parameter int CHW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [CHW-1:0]    waddr,
  input  logic [4*UW-1:0]   wdata,
  input  logic [CHW-1:0]    raddr,
  output logic [4*UW-1:0]   rdata
);

  logic [4*UW-1:0] mem [CH];

  // Addresses at or beyond CH match no entry, so such writes fall away.
  always_ff @(posedge clk) begin
    for (int e = 0; e < CH; e++) begin
      if (!rst) begin
        mem[e] <= '0;
      end else if (we && (waddr == CHW'(e))) begin
        mem[e] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int e = 0; e < CH; e++) begin
      if (raddr == CHW'(e)) rdata = mem[e];
    end
  end

endmodule

`default_nettype wire

// File: rtl/wino_f23_mc_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wino_f23_mc_engine : 3-stage Winograd F(2,3) core, multi-channel acc  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module wino_f23_mc_engine
  import wino_f23_mc_engine_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int GW    = GW_DEF,
  parameter int OW    = OW_DEF,
  parameter int CH    = 1,
  parameter int SHIFT = 0
) (
  input logic                 clk,
  input logic                 rst,
  wino_f23_mc_engine_if.slave bus
);

  localparam int CHW = chw_calc(CH);
  localparam int TW  = DW + 1;
  localparam int UW  = GW + 2;
  localparam int MW  = DW + GW + 3;
  localparam int PW  = DW + GW + 4;
  localparam int SW  = PW + 1;
  localparam int AW  = aw_calc(DW, GW, CH);
  localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

  logic                  s1_v, s2_v, z_valid, z_ovf;
  logic [2*OW-1:0]       z_data;
  logic [CHW-1:0]        ch_cnt, s1_ch, s2_ch;
  logic signed [TW-1:0]  s1_t [4];
  logic signed [MW-1:0]  s2_m [4];
  logic signed [AW-1:0]  acc0, acc1;

  logic adv, idle, w_fire, in_fire;

  assign adv           = !z_valid || bus.out_ready;
  assign idle          = !s1_v && !s2_v && (ch_cnt == '0) && !z_valid;
  assign bus.w_ready   = rst && idle;
  assign w_fire        = bus.w_we && bus.w_ready;
  assign bus.in_ready  = rst && adv && !w_fire;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = z_valid;
  assign bus.out_z     = z_data;
  assign bus.out_ovf   = z_ovf;

  logic signed [GW-1:0] g0, g1, g2;
  logic [4*UW-1:0]      w_u;
  assign g0  = bus.w_g[0*GW +: GW];
  assign g1  = bus.w_g[1*GW +: GW];
  assign g2  = bus.w_g[2*GW +: GW];
  assign w_u = {UW'(g2) <<< 1,
                UW'(g0) - UW'(g1) + UW'(g2),
                UW'(g0) + UW'(g1) + UW'(g2),
                UW'(g0) <<< 1};

  logic [4*UW-1:0] rd_u;

  wino_f23_wbank #(.CH(CH), .UW(UW), .CHW(CHW)) u_wbank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_fire),
    .waddr (bus.w_ch),
    .wdata (w_u),
    .raddr (s1_ch),
    .rdata (rd_u)
  );

  logic signed [DW-1:0] d [4];
  logic signed [TW-1:0] t [4];
  logic signed [UW-1:0] u [4];
  logic signed [MW-1:0] m [4];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign d[k] = bus.in_d[k*DW +: DW];
    assign u[k] = rd_u[k*UW +: UW];
    assign m[k] = MW'(s1_t[k]) * MW'(u[k]);
  end

  assign t[0] = TW'(d[0]) - TW'(d[2]);
  assign t[1] = TW'(d[1]) + TW'(d[2]);
  assign t[2] = TW'(d[2]) - TW'(d[1]);
  assign t[3] = TW'(d[1]) - TW'(d[3]);

  // Both sums are always even, so the halving shift is exact.
  logic signed [SW-1:0] sum0, sum1;
  logic signed [PW-1:0] p0, p1;
  logic signed [AW-1:0] nxt0, nxt1, r0, r1;
  logic [OW-1:0]        zs0, zs1;
  logic                 ovf_n;

  assign sum0  = SW'(s2_m[0]) + SW'(s2_m[1]) + SW'(s2_m[2]);
  assign sum1  = SW'(s2_m[1]) - SW'(s2_m[2]) - SW'(s2_m[3]);
  assign p0    = PW'(sum0 >>> 1);
  assign p1    = PW'(sum1 >>> 1);
  assign nxt0  = (s2_ch == '0) ? AW'(p0) : acc0 + AW'(p0);
  assign nxt1  = (s2_ch == '0) ? AW'(p1) : acc1 + AW'(p1);
  assign r0    = nxt0 >>> SHIFT;
  assign r1    = nxt1 >>> SHIFT;
  assign zs0   = OW'(sat_val(64'(r0), OW));
  assign zs1   = OW'(sat_val(64'(r1), OW));
  assign ovf_n = sat_ovf(64'(r0), OW) || sat_ovf(64'(r1), OW);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      z_valid <= 1'b0;
      z_ovf   <= 1'b0;
      z_data  <= '0;
      ch_cnt  <= '0;
      s1_ch   <= '0;
      s2_ch   <= '0;
      s1_t    <= '{default: '0};
      s2_m    <= '{default: '0};
      acc0    <= '0;
      acc1    <= '0;
    end else if (adv) begin
      s1_v <= in_fire;
      if (in_fire) begin
        s1_t   <= t;
        s1_ch  <= ch_cnt;
        ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
      end
      s2_v    <= s1_v;
      s2_m    <= m;
      s2_ch   <= s1_ch;
      z_valid <= 1'b0;
      if (s2_v) begin
        acc0 <= nxt0;
        acc1 <= nxt1;
        if (s2_ch == LAST_CH) begin
          z_valid <= 1'b1;
          z_data  <= {zs1, zs0};
          z_ovf   <= ovf_n;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wino_f23_mc_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wino_f23_mc_engine : directed bench, one CH=1 and one CH=2 core    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_wino_f23_mc_engine;
  import wino_f23_mc_engine_pkg::*;

  localparam int DW = 10;
  localparam int GW = 10;
  localparam int OW = 10;

  typedef struct { int z0; int z1; bit ovf; } res_t;

  logic clk  = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  res_t q1[$];
  res_t q2[$];

  always #5 clk = ~clk;

  wino_f23_mc_engine_if #(.DW(DW), .GW(GW), .OW(OW), .CH(1)) bus1 ();
  wino_f23_mc_engine_if #(.DW(DW), .GW(GW), .OW(OW), .CH(2)) bus2 ();

  wino_f23_mc_engine #(.DW(DW), .GW(GW), .OW(OW), .CH(1), .SHIFT(0)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1));
  wino_f23_mc_engine #(.DW(DW), .GW(GW), .OW(OW), .CH(2), .SHIFT(0)) u_dut2 (
    .clk(clk), .rst(rst2), .bus(bus2));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic [2*OW-1:0] z, input logic ovf);
    res_t r;
    r.z0  = int'($signed(z[OW-1:0]));
    r.z1  = int'($signed(z[2*OW-1:OW]));
    r.ovf = ovf;
    return r;
  endfunction

  // Direct 3-tap convolution: the result Winograd must reproduce.
  function automatic int conv(input int a, input int b, input int c,
                              input int g0, input int g1, input int g2);
    return a * g0 + b * g1 + c * g2;
  endfunction

  function automatic int clampz(input int v);
    return (v > 511) ? 511 : ((v < -512) ? -512 : v);
  endfunction

  // Output monitor; also verifies outputs stay frozen while stalled.
  logic [2*OW-1:0] hold1 = '0, hold2 = '0;
  logic            hov1 = 1'b0, hov2 = 1'b0;
  bit              stall1 = 0, stall2 = 0;
  always @(negedge clk) begin
    if (stall1) begin
      check("hold_valid1", bus1.out_valid, 1);
      check("hold_z1", bus1.out_z, hold1);
      check("hold_ovf1", bus1.out_ovf, hov1);
    end
    if (stall2) begin
      check("hold_valid2", bus2.out_valid, 1);
      check("hold_z2", bus2.out_z, hold2);
    end
    stall1 = rst1 && bus1.out_valid && !bus1.out_ready;
    stall2 = rst2 && bus2.out_valid && !bus2.out_ready;
    hold1  = bus1.out_z;
    hov1   = bus1.out_ovf;
    hold2  = bus2.out_z;
    if (rst1 && bus1.out_valid && bus1.out_ready) q1.push_back(mk(bus1.out_z, bus1.out_ovf));
    if (rst2 && bus2.out_valid && bus2.out_ready) q2.push_back(mk(bus2.out_z, bus2.out_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int which);
    return (which == 1) ? q1.size() : q2.size();
  endfunction

  function automatic logic ready_of(input int which);
    return (which == 1) ? bus1.in_ready : bus2.in_ready;
  endfunction

  function automatic logic wready_of(input int which);
    return (which == 1) ? bus1.w_ready : bus2.w_ready;
  endfunction

  task automatic set_in(input int which, input bit v, input int d0, input int d1,
                        input int d2, input int d3);
    if (which == 1) begin
      bus1.in_valid = v;
      bus1.in_d     = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    end else begin
      bus2.in_valid = v;
      bus2.in_d     = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    end
  endtask

  task automatic set_w(input int which, input bit we, input int ch, input int g0,
                       input int g1, input int g2);
    if (which == 1) begin
      bus1.w_we = we;
      bus1.w_ch = 1'(ch);
      bus1.w_g  = {GW'(g2), GW'(g1), GW'(g0)};
    end else begin
      bus2.w_we = we;
      bus2.w_ch = 1'(ch);
      bus2.w_g  = {GW'(g2), GW'(g1), GW'(g0)};
    end
  endtask

  task automatic write_w(input int which, input int ch, input int g0, input int g1,
                         input int g2);
    bit ok = 0;
    set_w(which, 1, ch, g0, g1, g2);
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      ok = wready_of(which);
      tick();
    end
    set_w(which, 0, 0, 0, 0, 0);
    check("w_ack", ok, 1);
  endtask

  task automatic send(input int which, input int d0, input int d1, input int d2,
                      input int d3);
    bit ok = 0;
    set_in(which, 1, d0, d1, d2, d3);
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      ok = ready_of(which);
      tick();
    end
    set_in(which, 0, 0, 0, 0, 0);
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input int which, input int n);
    for (int k = 0; k < 40 && qsize(which) < n; k++) tick();
    repeat (4) tick();
    check($sformatf("count%0d", which), qsize(which), n);
  endtask

  task automatic expect_q(input int which, input int idx, input string tag,
                          input int e0, input int e1);
    res_t r;
    if (idx >= qsize(which)) begin
      check({tag, "_missing"}, qsize(which), idx + 1);
    end else begin
      r = (which == 1) ? q1[idx] : q2[idx];
      check({tag, "_z0"}, r.z0, clampz(e0));
      check({tag, "_z1"}, r.z1, clampz(e1));
      check({tag, "_ovf"}, r.ovf, (clampz(e0) != e0) || (clampz(e1) != e1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int td[6][4];

  initial begin
    int lat;
    set_in(1, 0, 0, 0, 0, 0);
    set_in(2, 0, 0, 0, 0, 0);
    set_w(1, 0, 0, 0, 0, 0);
    set_w(2, 0, 0, 0, 0, 0);
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid1", bus1.out_valid, 0);
    check("rst_z1", bus1.out_z, 0);
    check("rst_ovf1", bus1.out_ovf, 0);
    check("rst_in_ready1", bus1.in_ready, 0);
    check("rst_w_ready1", bus1.w_ready, 0);
    check("rst_valid2", bus2.out_valid, 0);
    check("rst_z2", bus2.out_z, 0);
    rst1 = 1'b1;
    rst2 = 1'b1;
    tick();

    // Basic tile and 3-cycle latency
    write_w(1, 0, 1, 2, 1);
    set_in(1, 1, 1, 2, 3, 4);
    #1;
    check("t1_in_ready", bus1.in_ready, 1);
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (n == 0) set_in(1, 0, 0, 0, 0, 0);
      lat++;
      if (bus1.out_valid) break;
    end
    check("t1_latency", lat, 3);
    drain(1, 1);
    expect_q(1, 0, "t1", conv(1, 2, 3, 1, 2, 1), conv(2, 3, 4, 1, 2, 1));

    // Write to a channel beyond CH is acknowledged but leaves taps alone
    write_w(1, 1, 5, 5, 5);
    send(1, 1, 2, 3, 4);
    drain(1, 2);
    expect_q(1, 1, "oob", 8, 12);

    // Saturation at both rails
    write_w(1, 0, 511, 511, 511);
    send(1, 511, 511, 511, 511);
    send(1, -512, -512, -512, -512);
    drain(1, 4);
    expect_q(1, 2, "sat_hi", conv(511, 511, 511, 511, 511, 511), conv(511, 511, 511, 511, 511, 511));
    expect_q(1, 3, "sat_lo", conv(-512, -512, -512, 511, 511, 511), conv(-512, -512, -512, 511, 511, 511));

    // Streaming with downstream back-pressure
    write_w(1, 0, 1, 2, 1);
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 4; k++)
        td[i][k] = (i == 5) ? 300 : ((i * 53 + k * 29) % 160) - 80;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1, td[i][0], td[i][1], td[i][2], td[i][3]);
      end
      begin
        repeat (4) tick();
        bus1.out_ready = 1'b0;
        repeat (3) tick();
        #1;
        check("stall_in_ready", bus1.in_ready, 0);
        tick();
        tick();
        bus1.out_ready = 1'b1;
      end
    join
    drain(1, 10);
    for (int i = 0; i < 6; i++)
      expect_q(1, 4 + i, $sformatf("stream%0d", i),
               conv(td[i][0], td[i][1], td[i][2], 1, 2, 1),
               conv(td[i][1], td[i][2], td[i][3], 1, 2, 1));

    // Two-channel accumulation
    write_w(2, 0, 1, 0, 0);
    write_w(2, 1, 0, 0, 1);
    send(2, 5, 6, 7, 8);
    send(2, 1, 2, 3, 4);
    drain(2, 1);
    expect_q(2, 0, "t2", conv(5, 6, 7, 1, 0, 0) + conv(1, 2, 3, 0, 0, 1),
             conv(6, 7, 8, 1, 0, 0) + conv(2, 3, 4, 0, 0, 1));

    // Reset mid-tile drops the partial sum and clears the weights
    send(2, 9, 9, 9, 9);
    rst2 = 1'b0;
    #1;
    check("t5_in_ready_rst", bus2.in_ready, 0);
    check("t5_w_ready_rst", bus2.w_ready, 0);
    tick();
    rst2 = 1'b1;
    #1;
    check("t5_valid", bus2.out_valid, 0);
    check("t5_z", bus2.out_z, 0);
    check("t5_idle", bus2.w_ready, 1);
    tick();
    send(2, 5, 6, 7, 8);
    send(2, 1, 2, 3, 4);
    drain(2, 2);
    expect_q(2, 1, "t5", 0, 0);

    // Write and tile together while idle: write first, tile next cycle
    write_w(2, 1, 0, 0, 1);
    set_w(2, 1, 0, 0, 1, 0);
    set_in(2, 1, 5, 6, 7, 8);
    #1;
    check("t6_w_ready", bus2.w_ready, 1);
    check("t6_in_ready", bus2.in_ready, 0);
    tick();
    set_w(2, 0, 0, 0, 0, 0);
    #1;
    check("t6_in_ready_next", bus2.in_ready, 1);
    tick();
    set_in(2, 0, 0, 0, 0, 0);
    send(2, 1, 2, 3, 4);
    drain(2, 3);
    expect_q(2, 2, "t6", conv(5, 6, 7, 0, 1, 0) + conv(1, 2, 3, 0, 0, 1),
             conv(6, 7, 8, 0, 1, 0) + conv(2, 3, 4, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
